// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, symmetric debounce,
// level output plus press/release/long/auto-repeat pulses per key.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | key released (debounced level 0)
// ST_PRESSED | key held, hold_cnt counting toward the long-press threshold
// ST_LONG    | long press reached, rep_cnt pacing auto-repeat pulses
module key_debounce_multi #(
   parameter int N_KEYS     = 4,
   parameter int DEB_CNT    = 1_000_000,
   parameter int LONG_CYC   = 50_000_000,
   parameter int REPEAT_CYC = 10_000_000,
   parameter bit REPEAT_EN  = 1'b1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] long_pulse,
   output logic [N_KEYS-1:0] repeat_pulse,
   output logic              any_press
);

   localparam int DEB_W    = $clog2(DEB_CNT);
   localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
   localparam int HOLD_W   = $clog2(HOLD_MAX);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CNT - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYC - 1);
   localparam logic              RAW_IDLE  = ACTIVE_LOW;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_LONG    = 2'd2
   } key_st_t;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic              sync1, sync2, s;
      logic              lvl, lvl_nxt, accept;
      logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
      logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
      logic [HOLD_W-1:0] rep_cnt, rep_cnt_nxt;
      key_st_t           state, state_nxt;
      logic              press_q, release_q, long_q, repeat_q;
      logic              press_nxt, release_nxt, long_nxt, repeat_nxt;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
         end else begin
            sync1 <= key[i];
            sync2 <= sync1;
         end
      end

      assign s      = sync2 ^ ACTIVE_LOW;
      assign accept = (s != lvl) && (deb_cnt == DEB_LAST);

      // Counters advance only while the synchronised input agrees with the
      // pressed level, so a release bounce freezes long/repeat timing.
      always_comb begin
         deb_cnt_nxt  = '0;
         lvl_nxt      = lvl;
         state_nxt    = state;
         hold_cnt_nxt = hold_cnt;
         rep_cnt_nxt  = rep_cnt;
         press_nxt    = 1'b0;
         release_nxt  = 1'b0;
         long_nxt     = 1'b0;
         repeat_nxt   = 1'b0;
         if ((s != lvl) && !accept) deb_cnt_nxt = deb_cnt + DEB_W'(1);
         if (accept) lvl_nxt = ~lvl;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state_nxt    = ST_PRESSED;
                  hold_cnt_nxt = '0;
                  rep_cnt_nxt  = '0;
                  press_nxt    = 1'b1;
               end
            end
            ST_PRESSED: begin
               if (accept) begin
                  state_nxt    = ST_IDLE;
                  hold_cnt_nxt = '0;
                  rep_cnt_nxt  = '0;
                  release_nxt  = 1'b1;
               end else if (s) begin
                  if (hold_cnt == LONG_LAST) begin
                     state_nxt   = ST_LONG;
                     rep_cnt_nxt = '0;
                     long_nxt    = 1'b1;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                  end
               end
            end
            ST_LONG: begin
               if (accept) begin
                  state_nxt    = ST_IDLE;
                  hold_cnt_nxt = '0;
                  rep_cnt_nxt  = '0;
                  release_nxt  = 1'b1;
               end else if (s && REPEAT_EN) begin
                  if (rep_cnt == REP_LAST) begin
                     rep_cnt_nxt = '0;
                     repeat_nxt  = 1'b1;
                  end else begin
                     rep_cnt_nxt = rep_cnt + HOLD_W'(1);
                  end
               end
            end
            default: begin
               state_nxt    = ST_IDLE;
               hold_cnt_nxt = '0;
               rep_cnt_nxt  = '0;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            state     <= ST_IDLE;
            lvl       <= 1'b0;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state     <= state_nxt;
            lvl       <= lvl_nxt;
            deb_cnt   <= deb_cnt_nxt;
            hold_cnt  <= hold_cnt_nxt;
            rep_cnt   <= rep_cnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            repeat_q  <= repeat_nxt;
         end
      end

      assign key_state[i]     = lvl;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign long_pulse[i]    = long_q;
      assign repeat_pulse[i]  = repeat_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) any_press <= 1'b0;
      else      any_press <= |press_pulse;
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: two channels, short timing parameters,
// a second instance with auto-repeat disabled driven by the same stimulus.
module tb_key_debounce_multi;

   logic       clk, rst;
   logic [1:0] key;
   logic [1:0] key_state, press_pulse, release_pulse, long_pulse, repeat_pulse;
   logic       any_press;
   logic [1:0] key_state_nr, press_pulse_nr, release_pulse_nr, long_pulse_nr, repeat_pulse_nr;
   logic       any_press_nr;

   key_debounce_multi #(.N_KEYS(2), .DEB_CNT(4), .LONG_CYC(20), .REPEAT_CYC(8),
                        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .key(key), .key_state(key_state),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .any_press(any_press));

   key_debounce_multi #(.N_KEYS(2), .DEB_CNT(4), .LONG_CYC(20), .REPEAT_CYC(8),
                        .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)) dut_nr (
      .clk(clk), .rst(rst), .key(key), .key_state(key_state_nr),
      .press_pulse(press_pulse_nr), .release_pulse(release_pulse_nr),
      .long_pulse(long_pulse_nr), .repeat_pulse(repeat_pulse_nr), .any_press(any_press_nr));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int n_press[2], n_rel[2], n_long[2], n_rep[2];
   int t_press[2], t_rel[2], t_long[2];
   int n_any = 0, t_any = 0, n_overlap = 0;
   int n_long_nr = 0, t_long_nr = 0, n_rep_nr = 0;
   int rep_t[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int c = 0; c < 2; c++) begin
         n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
         t_press[c] = 0; t_rel[c] = 0; t_long[c] = 0;
      end
      forever begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            if (press_pulse[c])   begin n_press[c]++; t_press[c] = cyc; end
            if (release_pulse[c]) begin n_rel[c]++;   t_rel[c]   = cyc; end
            if (long_pulse[c])    begin n_long[c]++;  t_long[c]  = cyc; end
            if (repeat_pulse[c])  n_rep[c]++;
         end
         if (repeat_pulse[0]) rep_t.push_back(cyc);
         if (any_press) begin n_any++; t_any = cyc; end
         if ((press_pulse & release_pulse) != 2'b00) n_overlap++;
         if (long_pulse_nr[0]) begin n_long_nr++; t_long_nr = cyc; end
         if (repeat_pulse_nr != 2'b00) n_rep_nr++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int all_outs();
      return int'({key_state, press_pulse, release_pulse, long_pulse, repeat_pulse, any_press});
   endfunction

   function automatic int all_outs_nr();
      return int'({key_state_nr, press_pulse_nr, release_pulse_nr, long_pulse_nr,
                   repeat_pulse_nr, any_press_nr});
   endfunction

   function automatic int total_pulses();
      return n_press[0] + n_press[1] + n_rel[0] + n_rel[1] + n_long[0] + n_long[1]
             + n_rep[0] + n_rep[1] + n_any;
   endfunction

   int b_tot, b_p0, b_r0, b_l0, b_any, b_ch1, b_rep, b_lnr, b_p1, b_r1, b_l1;
   int t0, t_r, t_last, p;

   initial begin
      rst = 1'b0;
      key = 2'b00;
      repeat (3) tick();
      check_val("rst_outs", all_outs(), 0);
      check_val("rst_outs_nr", all_outs_nr(), 0);

      key = 2'b11;
      rst = 1'b1;
      b_tot = total_pulses();
      repeat (50) tick();
      check_val("idle_no_pulses", total_pulses() - b_tot, 0);
      check_val("idle_state", int'(key_state), 0);

      // clean press, held 12 cycles after press_pulse, then release
      b_p0 = n_press[0]; b_r0 = n_rel[0]; b_l0 = n_long[0]; b_any = n_any;
      b_ch1 = n_press[1] + n_rel[1] + n_long[1] + n_rep[1];
      key[0] = 1'b0;
      t0 = cyc;
      repeat (5) tick();
      check_val("ks_before_E5", int'(key_state[0]), 0);
      tick();
      check_val("ks_at_E5", int'(key_state[0]), 1);
      check_val("press_at_E5", int'(press_pulse), 1);
      tick();
      check_val("press_one_cycle", int'(press_pulse), 0);
      check_val("any_press_next", int'(any_press), 1);
      repeat (11) tick();
      key[0] = 1'b1;
      t_r = cyc;
      repeat (10) tick();
      check_val("press_cnt", n_press[0] - b_p0, 1);
      check_val("press_lat", t_press[0] - t0, 6);
      check_val("any_cnt", n_any - b_any, 1);
      check_val("any_lat", t_any - t_press[0], 1);
      check_val("rel_cnt", n_rel[0] - b_r0, 1);
      check_val("rel_lat", t_rel[0] - t_r, 6);
      check_val("short_no_long", n_long[0] - b_l0, 0);
      check_val("ch1_quiet", n_press[1] + n_rel[1] + n_long[1] + n_rep[1], b_ch1);
      check_val("ks_after_rel", int'(key_state), 0);

      // bouncing press, then hold into long press and auto-repeat
      b_p0 = n_press[0]; b_r0 = n_rel[0]; b_l0 = n_long[0]; b_rep = rep_t.size();
      b_lnr = n_long_nr;
      for (int k = 0; k < 5; k++) begin
         key[0] = 1'b0;
         repeat (3) tick();
         key[0] = 1'b1;
         tick();
      end
      key[0] = 1'b0;
      t_last = cyc;
      repeat (70) tick();
      check_val("bounce_press_cnt", n_press[0] - b_p0, 1);
      check_val("bounce_press_lat", t_press[0] - t_last, 6);
      p = t_press[0];
      check_val("long_cnt", n_long[0] - b_l0, 1);
      check_val("long_lat", t_long[0] - p, 20);
      check_val("long_nr_lat", t_long_nr - p, 20);
      check_val("long_nr_cnt", n_long_nr - b_lnr, 1);
      check_val("rep_cnt", rep_t.size() - b_rep, 5);
      for (int k = 0; k < 5; k++) begin
         if (b_rep + k < rep_t.size())
            check_val("rep_time", rep_t[b_rep + k] - p, 28 + 8 * k);
      end
      key[0] = 1'b1;
      t_r = cyc;
      repeat (10) tick();
      check_val("long_rel_cnt", n_rel[0] - b_r0, 1);
      check_val("long_rel_lat", t_rel[0] - t_r, 6);
      check_val("no_rep_after_rel", rep_t.size() - b_rep, 5);
      check_val("ks_after_long_rel", int'(key_state), 0);

      // 2-cycle high glitch during hold freezes hold_cnt, no release
      b_r0 = n_rel[0]; b_l0 = n_long[0]; b_rep = rep_t.size();
      key[0] = 1'b0;
      repeat (11) tick();
      key[0] = 1'b1;
      repeat (2) tick();
      key[0] = 1'b0;
      repeat (17) tick();
      p = t_press[0];
      check_val("glitch_no_rel", n_rel[0] - b_r0, 0);
      check_val("glitch_long_cnt", n_long[0] - b_l0, 1);
      check_val("glitch_long_lat", t_long[0] - p, 22);
      key[0] = 1'b1;
      repeat (10) tick();
      check_val("glitch_rel_cnt", n_rel[0] - b_r0, 1);
      check_val("glitch_no_rep", rep_t.size() - b_rep, 0);

      // both channels together, then reset while in LONG
      b_l0 = n_long[0]; b_l1 = n_long[1];
      key = 2'b00;
      repeat (6) tick();
      check_val("both_press", int'(press_pulse), 3);
      repeat (22) tick();
      check_val("both_long0", n_long[0] - b_l0, 1);
      check_val("both_long1", n_long[1] - b_l1, 1);
      b_r0 = n_rel[0]; b_r1 = n_rel[1]; b_p0 = n_press[0]; b_p1 = n_press[1];
      rst = 1'b0;
      #1;
      check_val("mid_rst_outs", all_outs(), 0);
      check_val("mid_rst_outs_nr", all_outs_nr(), 0);
      key = 2'b11;
      repeat (3) tick();
      rst = 1'b1;
      repeat (20) tick();
      check_val("rst_no_rel", (n_rel[0] - b_r0) + (n_rel[1] - b_r1), 0);
      check_val("rst_no_press", (n_press[0] - b_p0) + (n_press[1] - b_p1), 0);
      check_val("rst_ks", int'(key_state), 0);

      check_val("no_press_rel_overlap", n_overlap, 0);
      check_val("nr_no_repeat", n_rep_nr, 0);

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
